receive_controller: RTL

//   Receiving end of the byte-serial link driven by the send controller:

---
 rtl/receive_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/receive_controller.sv
// Byte-serial link receiver: synchronises the async data clock, data and sync
// lines, deframes MSB-first bytes and queues them in a show-ahead FIFO.
module receive_controller #(
  parameter int SyncStages   = 2,
  parameter int FIFODepthLog = 4,
  parameter int ByteCntWidth = 16
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    dataClkIn,
  input  logic                    dataIn,
  input  logic                    syncIn,
  output logic [7:0]              rx_byte,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    frameErr,
  output logic                    overflow,
  output logic [ByteCntWidth-1:0] byteCnt
);

  localparam int Depth = 1 << FIFODepthLog;
  localparam int PtrW  = FIFODepthLog + 1;

  typedef enum logic {HUNT, SHIFT} state_t;

  logic [SyncStages-1:0] clk_sync, data_sync, sync_sync;
  logic                  clk_prev;
  logic                  clk_s, data_s, sync_s, dclk_edge;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       push;
  logic [7:0] push_byte;

  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic            full, pop, wr_en;

  // All three lines go through identical depth so data/sync stay aligned with the clock edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_sync  <= '0;
      data_sync <= '0;
      sync_sync <= '0;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SyncStages-2:0], dataClkIn};
      data_sync <= {data_sync[SyncStages-2:0], dataIn};
      sync_sync <= {sync_sync[SyncStages-2:0], syncIn};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s     = clk_sync[SyncStages-1];
  assign data_s    = data_sync[SyncStages-1];
  assign sync_s    = sync_sync[SyncStages-1];
  assign dclk_edge = clk_s & ~clk_prev;

  assign push      = dclk_edge && (state == SHIFT) && !sync_s && (bit_cnt == 3'd7);
  assign push_byte = {shreg, data_s};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= HUNT;
      bit_cnt  <= '0;
      shreg    <= '0;
      frameErr <= 1'b0;
    end else begin
      frameErr <= 1'b0;
      if (dclk_edge) begin
        case (state)
          HUNT: begin
            if (sync_s) begin
              shreg   <= {6'b0, data_s};
              bit_cnt <= 3'd1;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (sync_s) begin
              frameErr <= 1'b1;
              shreg    <= {6'b0, data_s};
              bit_cnt  <= 3'd1;
            end else if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= HUNT;
            end else begin
              shreg   <= {shreg[5:0], data_s};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // rx_valid is the registered non-empty flag, so it doubles as the pop qualifier.
  assign full  = (wr_ptr[PtrW-1] != rd_ptr[PtrW-1]) &&
                 (wr_ptr[PtrW-2:0] == rd_ptr[PtrW-2:0]);
  assign pop   = rx_valid & rx_ready;
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_next = wr_ptr + PtrW'(wr_en);
    rd_next = rd_ptr + PtrW'(pop);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PtrW-2:0]] <= push_byte;
  end

  // Head register is loaded from the incoming byte when it lands at the next read slot.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      overflow <= 1'b0;
      byteCnt  <= '0;
    end else begin
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      rx_valid <= (wr_next != rd_next);
      if (wr_next != rd_next) begin
        if (wr_en && (wr_ptr[PtrW-2:0] == rd_next[PtrW-2:0]))
          rx_byte <= push_byte;
        else
          rx_byte <= mem[rd_next[PtrW-2:0]];
      end
      if (push && !wr_en) overflow <= 1'b1;
      if (wr_en) byteCnt <= byteCnt + ByteCntWidth'(1);
    end
  end

endmodule
